// File: rtl/voice_amp_mixer.sv
// Multi-voice envelope scaler and mixer: scales each oscillator voice by its envelope,
// sums the unmuted voices, applies master volume and saturates to a signed sample.
module voice_amp_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int WAVE_W     = 12,
    parameter int ENV_W      = 8,
    parameter int VOL_W      = 4,
    parameter int OUT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES*WAVE_W-1:0] wave_in,
    input  logic [NUM_VOICES*ENV_W-1:0]  env_in,
    input  logic [NUM_VOICES-1:0]        voice_mute,
    input  logic [VOL_W-1:0]             master_vol,
    output logic signed [OUT_W-1:0]      mix_out,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W  = WAVE_W + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int GAIN_W = ((ENV_W > VOL_W) ? ENV_W : VOL_W) + 1;
    localparam int PROD_W = ACC_W + GAIN_W;

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        VOLUME,
        OUTPUT
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_VOICES*WAVE_W-1:0] wave_reg;
    logic [NUM_VOICES*ENV_W-1:0]  env_reg;
    logic [NUM_VOICES-1:0]        mute_reg;
    logic [VOL_W-1:0]             vol_reg;
    logic [IDX_W-1:0]             idx_reg;
    logic signed [ACC_W-1:0]      acc_reg;
    logic signed [PROD_W-1:0]     m_reg;
    logic signed [OUT_W-1:0]      mix_out_reg;
    logic                         mix_valid_reg;
    logic                         overrun_reg;

    logic [WAVE_W-1:0] wave_arr [NUM_VOICES];
    logic [ENV_W-1:0]  env_arr  [NUM_VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
            assign wave_arr[gi] = wave_reg[gi*WAVE_W +: WAVE_W];
            assign env_arr[gi]  = env_reg[gi*ENV_W +: ENV_W];
        end
    endgenerate

    logic [WAVE_W-1:0] cur_wave;
    logic [ENV_W-1:0]  cur_env;
    logic              cur_mute;

    always_comb begin
        cur_wave = '0;
        cur_env  = '0;
        cur_mute = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_wave = wave_arr[i];
                cur_env  = env_arr[i];
                cur_mute = mute_reg[i];
            end
        end
    end

    // Offset-binary to two's complement: subtracting the midpoint just flips the MSB.
    logic signed [WAVE_W-1:0] wave_signed;
    assign wave_signed = {~cur_wave[WAVE_W-1], cur_wave[WAVE_W-2:0]};

    // Single shared multiplier: voice x envelope in SCALE, accumulator x volume in VOLUME.
    logic signed [ACC_W-1:0]  mul_a;
    logic signed [GAIN_W-1:0] mul_b;
    logic signed [PROD_W-1:0] mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_reg == VOLUME) begin
            mul_a = acc_reg;
            mul_b = {{(GAIN_W-VOL_W){1'b0}}, vol_reg};
        end else begin
            mul_a = {{(ACC_W-WAVE_W){wave_signed[WAVE_W-1]}}, wave_signed};
            mul_b = {{(GAIN_W-ENV_W){1'b0}}, cur_env};
        end
    end

    assign mul_p = mul_a * mul_b;

    // Taking bits above ENV_W is the floor shift; the scaled voice always fits in ACC_W.
    logic signed [ACC_W-1:0]  voice_term;
    logic signed [PROD_W-1:0] vol_scaled;

    assign voice_term = mul_p[ENV_W +: ACC_W];
    assign vol_scaled = mul_p >>> VOL_W;

    logic signed [OUT_W-1:0] sat_val;

    generate
        if (OUT_W >= PROD_W) begin : g_no_sat
            assign sat_val = OUT_W'(m_reg);
        end else begin : g_sat
            localparam logic signed [PROD_W-1:0] SAT_MAX =
                {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

            always_comb begin
                sat_val = m_reg[OUT_W-1:0];
                if (m_reg > SAT_MAX) begin
                    sat_val = SAT_MAX[OUT_W-1:0];
                end else if (m_reg < SAT_MIN) begin
                    sat_val = SAT_MIN[OUT_W-1:0];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sample_tick) state_next = SCALE;
            SCALE:   if (idx_reg == IDX_W'(NUM_VOICES-1)) state_next = VOLUME;
            VOLUME:  state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wave_reg      <= '0;
            env_reg       <= '0;
            mute_reg      <= '0;
            vol_reg       <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            m_reg         <= '0;
            mix_out_reg   <= '0;
            mix_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mix_valid_reg <= 1'b0;
            if (sample_tick && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (sample_tick) begin
                        wave_reg <= wave_in;
                        env_reg  <= env_in;
                        mute_reg <= voice_mute;
                        vol_reg  <= master_vol;
                        acc_reg  <= '0;
                        idx_reg  <= '0;
                    end
                end
                SCALE: begin
                    if (!cur_mute) begin
                        acc_reg <= acc_reg + voice_term;
                    end
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                VOLUME: begin
                    m_reg <= vol_scaled;
                end
                OUTPUT: begin
                    mix_out_reg   <= sat_val;
                    mix_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mix_out   = mix_out_reg;
    assign mix_valid = mix_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_voice_amp_mixer.sv
// Directed bench for voice_amp_mixer: default-width instance plus a 12-bit output
// instance sharing the same stimulus to exercise saturation.
module tb_voice_amp_mixer;

    localparam int NV = 3;
    localparam int WW = 12;
    localparam int EW = 8;
    localparam int VW = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  sample_tick = 1'b0;
    logic [NV*WW-1:0]      wave_in = '0;
    logic [NV*EW-1:0]      env_in = '0;
    logic [NV-1:0]         voice_mute = '0;
    logic [VW-1:0]         master_vol = '0;
    logic signed [15:0]    mix_out;
    logic                  mix_valid;
    logic                  busy;
    logic                  overrun;
    logic signed [11:0]    mix_out_s;
    logic                  mix_valid_s;
    logic                  busy_s;
    logic                  overrun_s;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    voice_amp_mixer #(.NUM_VOICES(NV), .WAVE_W(WW), .ENV_W(EW), .VOL_W(VW), .OUT_W(16)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .wave_in(wave_in),
        .env_in(env_in), .voice_mute(voice_mute), .master_vol(master_vol),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    voice_amp_mixer #(.NUM_VOICES(NV), .WAVE_W(WW), .ENV_W(EW), .VOL_W(VW), .OUT_W(12)) dut_sat (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .wave_in(wave_in),
        .env_in(env_in), .voice_mute(voice_mute), .master_vol(master_vol),
        .mix_out(mix_out_s), .mix_valid(mix_valid_s), .busy(busy_s), .overrun(overrun_s)
    );

    // Pulses one tick and watches 12 cycles; latency counts edges after the tick edge.
    task automatic run_sample(input logic [NV*WW-1:0] w, input logic [NV*EW-1:0] e,
                              input logic [NV-1:0] m, input logic [VW-1:0] v,
                              input logic release_reset,
                              output int lat, output int nvalid,
                              output logic signed [15:0] out16,
                              output logic signed [11:0] out12);
        @(negedge clk);
        wave_in = w; env_in = e; voice_mute = m; master_vol = v;
        sample_tick = 1'b1;
        if (release_reset) reset = 1'b0;
        @(negedge clk);
        sample_tick = 1'b0;
        wave_in = '0; env_in = '0; voice_mute = '1; master_vol = '0;
        lat = -1; nvalid = 0; out16 = 'x; out12 = 'x;
        for (int c = 0; c < 12; c++) begin
            if (mix_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    out16 = mix_out;
                    out12 = mix_out_s;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mix_out, mix_valid, busy, overrun} !== 19'd0)
            $display("FAIL reset_outputs: got out=%0d valid=%b busy=%b ovr=%b want all 0",
                     mix_out, mix_valid, busy, overrun);
        else passes++;
        checks++;
        if ({mix_out_s, mix_valid_s, busy_s, overrun_s} !== 15'd0)
            $display("FAIL reset_outputs_sat: got out=%0d valid=%b busy=%b ovr=%b want all 0",
                     mix_out_s, mix_valid_s, busy_s, overrun_s);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_full_scale();
        int lat, nv;
        logic signed [15:0] o16;
        logic signed [11:0] o12;
        run_sample({NV{12'd4095}}, {NV{8'd255}}, 3'b000, 4'd15, 1'b0, lat, nv, o16, o12);
        checks++;
        if (lat !== 5) $display("FAIL full_latency: got %0d want 5", lat); else passes++;
        checks++;
        if (o16 !== 16'sd5734) $display("FAIL full_mix: got %0d want 5734", o16); else passes++;
        checks++;
        if (o12 !== 12'sd2047) $display("FAIL full_sat: got %0d want 2047", o12); else passes++;
        checks++;
        if (nv !== 1) $display("FAIL full_valid_count: got %0d want 1", nv); else passes++;
        checks++;
        if (mix_out !== 16'sd5734) $display("FAIL full_hold: got %0d want 5734", mix_out); else passes++;
    endtask

    task automatic test_full_negative();
        int lat, nv;
        logic signed [15:0] o16;
        logic signed [11:0] o12;
        run_sample({NV{12'd0}}, {NV{8'd255}}, 3'b000, 4'd15, 1'b0, lat, nv, o16, o12);
        checks++;
        if (o16 !== -16'sd5738) $display("FAIL neg_mix: got %0d want -5738", o16); else passes++;
        checks++;
        if (o12 !== -12'sd2048) $display("FAIL neg_sat: got %0d want -2048", o12); else passes++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL neg_no_overrun: got %b want 0", overrun); else passes++;
    endtask

    task automatic test_mute_mix();
        int lat, nv;
        logic signed [15:0] o16;
        logic signed [11:0] o12;
        run_sample({12'd2048, 12'd4095, 12'd3072}, {8'd255, 8'd255, 8'd128}, 3'b010, 4'd8,
                   1'b0, lat, nv, o16, o12);
        checks++;
        if (o16 !== 16'sd256) $display("FAIL mute_mix: got %0d want 256", o16); else passes++;
        checks++;
        if (o12 !== 12'sd256) $display("FAIL mute_mix_sat: got %0d want 256", o12); else passes++;
    endtask

    task automatic test_zero_gain();
        int lat, nv;
        logic signed [15:0] o16;
        logic signed [11:0] o12;
        run_sample({NV{12'd4095}}, {NV{8'd0}}, 3'b000, 4'd15, 1'b0, lat, nv, o16, o12);
        checks++;
        if (o16 !== 16'sd0) $display("FAIL zero_env: got %0d want 0", o16); else passes++;
        run_sample({NV{12'd4095}}, {NV{8'd255}}, 3'b000, 4'd0, 1'b0, lat, nv, o16, o12);
        checks++;
        if (o16 !== 16'sd0) $display("FAIL zero_vol: got %0d want 0", o16); else passes++;
    endtask

    task automatic test_overrun();
        int nv;
        logic signed [15:0] o16;
        o16 = 'x;
        @(negedge clk);
        wave_in = {NV{12'd4095}}; env_in = {NV{8'd255}}; voice_mute = '0; master_vol = 4'd15;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wave_in = '0; env_in = '0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            if (mix_valid) begin
                nv++;
                o16 = mix_out;
            end
            @(negedge clk);
        end
        checks++;
        if (nv !== 1) $display("FAIL overrun_valid_count: got %0d want 1", nv); else passes++;
        checks++;
        if (o16 !== 16'sd5734) $display("FAIL overrun_mix: got %0d want 5734", o16); else passes++;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (overrun !== 1'b0 || mix_out !== 16'sd0)
            $display("FAIL overrun_reset: got ovr=%b out=%0d want ovr=0 out=0", overrun, mix_out);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_scale();
        int lat, nv;
        logic signed [15:0] o16;
        logic signed [11:0] o12;
        @(negedge clk);
        wave_in = {NV{12'd4095}}; env_in = {NV{8'd255}}; voice_mute = '0; master_vol = 4'd15;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b want 1", busy); else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL midreset_busy_after: got %b want 0", busy); else passes++;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mix_valid) nv++;
        end
        checks++;
        if (nv !== 0) $display("FAIL midreset_no_valid: got %0d want 0", nv); else passes++;
        // Reset release coincides with the next tick, which must still be taken.
        run_sample({12'd2048, 12'd4095, 12'd3072}, {8'd255, 8'd255, 8'd128}, 3'b010, 4'd8,
                   1'b1, lat, nv, o16, o12);
        checks++;
        if (lat !== 5) $display("FAIL midreset_latency: got %0d want 5", lat); else passes++;
        checks++;
        if (o16 !== 16'sd256) $display("FAIL midreset_mix: got %0d want 256", o16); else passes++;
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_full_negative();
        test_mute_mix();
        test_zero_gain();
        test_overrun();
        test_reset_mid_scale();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
